ctl_bram_arbiter: RTL and testbench

Round-robin arbiter that shares the fabric-side port (port B) of the control-register BRAM among several requesters running on the same clock. Example requesters: the parameter-refresh sequencer, the sync/cycle loader, the FPGA-info writer and the delay-table loader. It accepts one read or write per cycle, drives the BRAM port from registers, and routes each read result back to the requester that issued it with a per-requester valid strobe. An optional lock lets one requester hold the port for an atomic burst, such as the sync-time plus cycle-table load.

---
 rtl/ctl_bram_arbiter_pkg.sv | 23 ++
 rtl/ctl_bram_arbiter_rr_pick.sv | 40 ++++
 rtl/ctl_bram_arbiter.sv | 152 +++++++++++++++
 tb/tb_ctl_bram_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctl_bram_arbiter_pkg.sv
// Shared types and defaults for the control-BRAM port-B arbiter.
// Optional lock support is selected with CTL_BRAM_ARB_LOCK_EN.
package ctl_bram_arbiter_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;
  localparam int N_REQ_MAX  = 8;

  // Tag id sized for the largest supported requester count
  localparam int TAG_ID_W = $clog2(N_REQ_MAX);

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/ctl_bram_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit at or above ptr,
// wrapping to the lowest set bit when none is found above.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] lo_idx;
  logic [IW-1:0] hi_idx;
  logic          hi_any;

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_any = 1'b0;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        any    = 1'b1;
      end
      if (req[i] && (IW'(i) >= ptr)) begin
        hi_idx = IW'(i);
        hi_any = 1'b1;
      end
    end
    idx = hi_any ? hi_idx : lo_idx;
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (IW'(i) == idx);
    end
  end

endmodule

// File: rtl/ctl_bram_arbiter.sv
// Round-robin arbiter sharing control-BRAM port B among requesters.
// Define CTL_BRAM_ARB_LOCK_EN to enable owner locking for bursts.
module ctl_bram_arbiter
  import ctl_bram_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ-1:0]    REQ_WE,
  input  logic [N_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [N_REQ*DATA_W-1:0] REQ_DIN,
  input  logic [N_REQ-1:0]    LOCK,
  output logic [N_REQ-1:0]    GNT,
  output logic [N_REQ-1:0]    RVALID,
  output logic [DATA_W-1:0]   RDATA,
  output logic                BRAM_WE,
  output logic [ADDR_W-1:0]   BRAM_ADDR,
  output logic [DATA_W-1:0]   BRAM_DIN,
  input  logic [DATA_W-1:0]   BRAM_DOUT
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] own;
  logic [IW-1:0] idx;
  logic          any;
  logic          acc;

  logic [N_REQ-1:0] own_mask;
  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] pick_gnt;
  logic [N_REQ-1:0] rv_next;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  rd_tag_t sr [RD_LAT];

  always_comb begin
    own_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      own_mask[i] = (IW'(i) == own);
    end
    req_eff = REQ;
    if (state == LOCKED) begin
      req_eff = REQ & own_mask;
    end
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_eff),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (idx),
    .any (any)
  );

  assign GNT   = RST_N ? pick_gnt : '0;
  assign acc   = any & RST_N;
  assign RDATA = BRAM_DOUT;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_we   = REQ_WE[i];
        sel_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
        sel_din  = REQ_DIN[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rv_next = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rv_next[i] = sr[RD_LAT-1].valid &&
                   (sr[RD_LAT-1].id == TAG_ID_W'(i));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BRAM_WE   <= 1'b0;
      BRAM_ADDR <= '0;
      BRAM_DIN  <= '0;
      ptr       <= '0;
      RVALID    <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        sr[k] <= '0;
      end
    end else begin
      BRAM_WE <= acc & sel_we;
      if (acc) begin
        BRAM_ADDR <= sel_addr;
        BRAM_DIN  <= sel_din;
        ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
      end
      // Writes occupy a slot too so returns stay aligned to accepts
      sr[0].valid <= acc & ~sel_we;
      sr[0].id    <= TAG_ID_W'(idx);
      for (int k = 1; k < RD_LAT; k++) begin
        sr[k] <= sr[k-1];
      end
      RVALID <= rv_next;
    end
  end

`ifdef CTL_BRAM_ARB_LOCK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      own   <= '0;
    end else if (acc) begin
      if (LOCK[idx]) begin
        state <= LOCKED;
        own   <= idx;
      end else begin
        state <= IDLE;
      end
    end else if (state == LOCKED && !REQ[own] && !LOCK[own]) begin
      state <= IDLE;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^LOCK;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      own   <= '0;
    end else begin
      state <= IDLE;
      own   <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_ctl_bram_arbiter.sv
// Directed bench for ctl_bram_arbiter with a read-first 2-cycle BRAM model.
// Lock expectations follow CTL_BRAM_ARB_LOCK_EN.
module tb_ctl_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [35:0] req_addr;
  logic [63:0] req_din;
  logic [3:0]  lock;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [15:0] rdata;
  logic        bram_we;
  logic [8:0]  bram_addr;
  logic [15:0] bram_din;
  logic [15:0] bram_dout;

  logic        pl_we;
  logic [8:0]  pl_a;
  logic [15:0] pl_d;
  logic [15:0] mem [512];
  logic [15:0] r1;
  logic [15:0] r2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ctl_bram_arbiter dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .REQ       (req),
    .REQ_WE    (req_we),
    .REQ_ADDR  (req_addr),
    .REQ_DIN   (req_din),
    .LOCK      (lock),
    .GNT       (gnt),
    .RVALID    (rvalid),
    .RDATA     (rdata),
    .BRAM_WE   (bram_we),
    .BRAM_ADDR (bram_addr),
    .BRAM_DIN  (bram_din),
    .BRAM_DOUT (bram_dout)
  );

  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else if (bram_we) mem[bram_addr] <= bram_din;
    r1 <= mem[bram_addr];
    r2 <= r1;
  end
  assign bram_dout = r2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_a(input int i, input logic [8:0] a);
    req_addr[i*9 +: 9] = a;
  endtask

  task automatic set_d(input int i, input logic [15:0] d);
    req_din[i*16 +: 16] = d;
  endtask

  task automatic preload(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req    = '0;
    req_we = '0;
    lock   = '0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_we", bram_we, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_din", bram_din, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] lk_req  [6] = '{4'b0100, 4'b0101, 4'b0101,
                              4'b0101, 4'b0101, 4'b0001};
  logic [3:0] lk_lock [6] = '{4'b0100, 4'b0100, 4'b0100,
                              4'b0100, 4'b0000, 4'b0000};
`ifdef CTL_BRAM_ARB_LOCK_EN
  logic [3:0] lk_exp  [6] = '{4'b0100, 4'b0100, 4'b0100,
                              4'b0100, 4'b0100, 4'b0001};
`else
  logic [3:0] lk_exp  [6] = '{4'b0100, 4'b0001, 4'b0100,
                              4'b0001, 4'b0100, 4'b0001};
`endif

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_we   = '0;
    lock     = '0;
    req_addr = '0;
    req_din  = '0;
    pl_we    = 1'b0;
    pl_a     = '0;
    pl_d     = '0;

    preload(9'h001, 16'hBEEF);
    for (int i = 0; i < 4; i++) preload(9'(9'h010 + i), 16'(16'hA000 + i));
    preload(9'h030, 16'h5555);

    // single reader
    do_reset();
    @(negedge clk);
    set_a(1, 9'h001);
    req = 4'b0010;
    #1 check("t1_gnt", gnt, 4'b0010);
    @(negedge clk);
    req = '0;
    check("t1_addr", bram_addr, 9'h001);
    check("t1_we", bram_we, 0);
    check("t1_rv_a", rvalid, 0);
    @(negedge clk);
    check("t1_rv_b", rvalid, 0);
    @(negedge clk);
    check("t1_rv", rvalid, 4'b0010);
    check("t1_rdata", rdata, 16'hBEEF);
    @(negedge clk);
    check("t1_rv_end", rvalid, 0);

    // round robin with all requesters
    do_reset();
    for (int i = 0; i < 4; i++) set_a(i, 9'(9'h010 + i));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 3 && k < 11) begin
        check("rr_rv", rvalid, 4'b0001 << ((k - 3) % 4));
        check("rr_rdata", rdata, 16'hA000 + ((k - 3) % 4));
      end else begin
        check("rr_rv_idle", rvalid, 0);
      end
      req = (k < 8) ? 4'b1111 : 4'b0000;
      #1 check("rr_gnt", gnt, (k < 8) ? (4'b0001 << (k % 4)) : 0);
    end

    // lock burst by requester 2 against requester 0
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 3) check("lk_rv", rvalid, 4'b0100);
      req  = lk_req[k];
      lock = lk_lock[k];
      #1 check("lk_gnt", gnt, lk_exp[k]);
    end
    @(negedge clk);
    req  = '0;
    lock = '0;
`ifdef CTL_BRAM_ARB_LOCK_EN
    // owner abandons its lock without a final access
    @(negedge clk);
    req  = 4'b0100;
    lock = 4'b0100;
    #1 check("ab_gnt0", gnt, 4'b0100);
    @(negedge clk);
    req = 4'b0001;
    #1 check("ab_gnt1", gnt, 0);
    @(negedge clk);
    lock = '0;
    #1 check("ab_gnt2", gnt, 0);
    @(negedge clk);
    #1 check("ab_gnt3", gnt, 4'b0001);
    @(negedge clk);
    req = '0;
`endif

    // write then read back
    do_reset();
    @(negedge clk);
    req    = 4'b1000;
    req_we = 4'b1000;
    set_a(3, 9'h020);
    set_d(3, 16'h1234);
    #1 check("wr_gnt", gnt, 4'b1000);
    @(negedge clk);
    check("wr_we", bram_we, 1);
    check("wr_addr", bram_addr, 9'h020);
    check("wr_din", bram_din, 16'h1234);
    req    = 4'b0001;
    req_we = '0;
    set_a(0, 9'h020);
    #1 check("rd_gnt", gnt, 4'b0001);
    @(negedge clk);
    req = '0;
    check("rd_we", bram_we, 0);
    check("rd_addr", bram_addr, 9'h020);
    @(negedge clk);
    check("wr_no_rv", rvalid, 0);
    @(negedge clk);
    check("rd_rv", rvalid, 4'b0001);
    check("rd_rdata", rdata, 16'h1234);
    @(negedge clk);
    check("rd_rv_end", rvalid, 0);

    // read-first on back-to-back read/write to one address
    do_reset();
    @(negedge clk);
    req = 4'b0010;
    set_a(1, 9'h030);
    #1 check("rf_gnt0", gnt, 4'b0010);
    @(negedge clk);
    req    = 4'b0100;
    req_we = 4'b0100;
    set_a(2, 9'h030);
    set_d(2, 16'hAAAA);
    #1 check("rf_gnt1", gnt, 4'b0100);
    @(negedge clk);
    req    = 4'b0010;
    req_we = '0;
    #1 check("rf_gnt2", gnt, 4'b0010);
    @(negedge clk);
    req = '0;
    check("rf_rv0", rvalid, 4'b0010);
    check("rf_old", rdata, 16'h5555);
    @(negedge clk);
    check("rf_rv1", rvalid, 0);
    @(negedge clk);
    check("rf_rv2", rvalid, 4'b0010);
    check("rf_new", rdata, 16'hAAAA);

    // reset mid-flight
    do_reset();
    @(negedge clk);
    req = 4'b0010;
    set_a(1, 9'h001);
    #1 check("mr_gnt", gnt, 4'b0010);
    @(negedge clk);
    req   = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("mr_gnt_rst", gnt, 0);
    check("mr_addr", bram_addr, 0);
    check("mr_rv", rvalid, 0);
    repeat (2) begin
      @(negedge clk);
      check("mr_rv_hold", rvalid, 0);
    end
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mr_rv_post", rvalid, 0);
    end
    @(negedge clk);
    req = 4'b1001;
    #1 check("mr_ptr0", gnt, 4'b0001);
    @(negedge clk);
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
